// File: rtl/f_pc_ctrl_if.sv
// ---------------------------------------------------------------------------
// f_pc_ctrl_if
// Bundles the signals between the next-PC sequencer and its neighbours:
// the hazard unit, the D-stage branch logic, CP0 and the PC register.
//
// Request side (driven by master, read by slave):
//   pc_cur        current PC register value
//   stall         fetch stall from the hazard unit (level)
//   br_req        taken branch/jump resolved in D (one-cycle pulse)
//   br_target     branch/jump target, valid with br_req
//   exc_req       exception/interrupt taken, from CP0
//   eret_req      ERET committing
//   epc           return address, valid with eret_req
// Response side (driven by slave, read by master):
//   npc           next PC to the PC register
//   pc_we         PC register write enable
//   exc_flush     flush F/D/E pipeline registers this cycle
//   redirect_busy a buffered branch redirect is pending
//   stall_cnt     saturating count of stalled cycles
// ---------------------------------------------------------------------------
interface f_pc_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [31:0]      pc_cur;
    logic             stall;
    logic             br_req;
    logic [31:0]      br_target;
    logic             exc_req;
    logic             eret_req;
    logic [31:0]      epc;

    logic [31:0]      npc;
    logic             pc_we;
    logic             exc_flush;
    logic             redirect_busy;
    logic [CNT_W-1:0] stall_cnt;

    // Request side: pipeline neighbours that feed the sequencer.
    modport master (
        output pc_cur,
        output stall,
        output br_req,
        output br_target,
        output exc_req,
        output eret_req,
        output epc,
        input  npc,
        input  pc_we,
        input  exc_flush,
        input  redirect_busy,
        input  stall_cnt
    );

    // Sequencer side.
    modport slave (
        input  pc_cur,
        input  stall,
        input  br_req,
        input  br_target,
        input  exc_req,
        input  eret_req,
        input  epc,
        output npc,
        output pc_we,
        output exc_flush,
        output redirect_busy,
        output stall_cnt
    );
endinterface

// File: rtl/f_pc_ctrl.sv
// ---------------------------------------------------------------------------
// f_pc_ctrl
// Next-PC sequencer and write-enable scheduler for the fetch-stage PC
// register. Arbitrates exception, ERET, D-stage branch/jump and sequential
// PC+4 redirects, and buffers a branch redirect that arrives while fetch is
// stalled so it can be applied as soon as the stall releases.
//
// Ports:
//   clk    system clock, all state updates on posedge
//   reset  synchronous active-low reset
//   bus    f_pc_ctrl_if.slave; see the interface file for signal meanings
//
// Parameters:
//   RESET_PC    value driven on npc while reset is asserted
//   EXC_VECTOR  exception handler entry address
//   CNT_W       width of the stall-cycle counter (must match bus CNT_W)
//
// Selection priority in every state:
//   exc_req > eret_req > stall > br_req > sequential
// ---------------------------------------------------------------------------
module f_pc_ctrl #(
    parameter logic [31:0] RESET_PC   = 32'h0000_3000,
    parameter logic [31:0] EXC_VECTOR = 32'h0000_4180,
    parameter int          CNT_W      = 16
) (
    input  logic        clk,
    input  logic        reset,
    f_pc_ctrl_if.slave  bus
);

    // RUN: no redirect buffered. HOLD: a branch target waits in pending_q.
    typedef enum logic [0:0] {
        RUN  = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [31:0]      pending_q;
    logic [31:0]      pending_d;
    logic [CNT_W-1:0] cnt_q;

    // Exception and ERET share every effect except the target address,
    // so one flag covers both for the state and counter logic.
    logic trap;
    logic [31:0] seq_pc;

    assign trap   = bus.exc_req | bus.eret_req;
    assign seq_pc = bus.pc_cur + 32'd4;

    // State register together with the buffered branch target.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= RUN;
            pending_q <= 32'h0000_0000;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
        end
    end

    // Next-state and pending-target update. A trap always discards any
    // buffered target; a stalled branch is captured (newest one wins);
    // leaving HOLD clears the buffer so a stale target can never reappear.
    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;

        if (trap) begin
            state_d   = RUN;
            pending_d = 32'h0000_0000;
        end else if (bus.stall) begin
            if (bus.br_req) begin
                state_d   = HOLD;
                pending_d = bus.br_target;
            end
        end else begin
            state_d   = RUN;
            pending_d = 32'h0000_0000;
        end
    end

    // Output decode. Reset forces a quiet interface regardless of requests
    // so the PC register is never written while reset is held.
    always_comb begin
        bus.npc           = RESET_PC;
        bus.pc_we         = 1'b0;
        bus.exc_flush     = 1'b0;
        bus.redirect_busy = 1'b0;

        if (reset) begin
            bus.redirect_busy = (state_q == HOLD);

            if (bus.exc_req) begin
                bus.npc       = EXC_VECTOR;
                bus.pc_we     = 1'b1;
                bus.exc_flush = 1'b1;
            end else if (bus.eret_req) begin
                bus.npc       = bus.epc;
                bus.pc_we     = 1'b1;
                bus.exc_flush = 1'b1;
            end else if (bus.stall) begin
                // Hold the current PC; npc is ignored while pc_we is low.
                bus.npc   = bus.pc_cur;
                bus.pc_we = 1'b0;
            end else if (bus.br_req) begin
                // A fresh branch supersedes anything buffered.
                bus.npc   = bus.br_target;
                bus.pc_we = 1'b1;
            end else if (state_q == HOLD) begin
                bus.npc   = pending_q;
                bus.pc_we = 1'b1;
            end else begin
                bus.npc   = seq_pc;
                bus.pc_we = 1'b1;
            end
        end
    end

    // Stall-cycle counter: counts only cycles lost to the hazard stall,
    // not trap cycles (which write the PC), and sticks at all-ones.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q <= '0;
        end else if (bus.stall && !trap && (cnt_q != '1)) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign bus.stall_cnt = cnt_q;

endmodule

// File: tb/tb_f_pc_ctrl.sv
// ---------------------------------------------------------------------------
// tb_f_pc_ctrl
// Directed testbench for f_pc_ctrl. A second instance with a 2-bit stall
// counter exercises counter saturation.
// ---------------------------------------------------------------------------
module tb_f_pc_ctrl;

    logic clk;
    logic reset;

    int num_checks = 0;
    int num_fails  = 0;

    f_pc_ctrl_if #(.CNT_W(16)) bus ();
    f_pc_ctrl_if #(.CNT_W(2))  bus2 ();

    f_pc_ctrl #(.CNT_W(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    f_pc_ctrl #(.CNT_W(2)) dut2 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value against its hand-computed expectation.
    task automatic checkOutput(input string tag, input logic [31:0] obs,
                               input logic [31:0] exp);
        num_checks++;
        if (obs !== exp) begin
            num_fails++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Drive one cycle's worth of inputs on the main instance and let the
    // combinational outputs settle before any check.
    task automatic applyStimulus(input logic s, input logic b,
                                 input logic [31:0] bt, input logic x,
                                 input logic e, input logic [31:0] ep,
                                 input logic [31:0] pc);
        bus.stall     = s;
        bus.br_req    = b;
        bus.br_target = bt;
        bus.exc_req   = x;
        bus.eret_req  = e;
        bus.epc       = ep;
        bus.pc_cur    = pc;
        #1;
    endtask

    // Advance one clock and step just past the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset          = 1'b0;
        bus2.stall     = 1'b0;
        bus2.br_req    = 1'b0;
        bus2.br_target = 32'h0;
        bus2.exc_req   = 1'b0;
        bus2.eret_req  = 1'b0;
        bus2.epc       = 32'h0;
        bus2.pc_cur    = 32'h0000_3000;

        // Reset: outputs forced, even with requests present.
        applyStimulus(0, 0, 32'h0, 0, 0, 32'h0, 32'h0000_3000);
        checkOutput("rst_npc",   bus.npc,           32'h0000_3000);
        checkOutput("rst_we",    32'(bus.pc_we),    32'h0);
        checkOutput("rst_cnt",   32'(bus.stall_cnt), 32'h0);
        checkOutput("rst_flush", 32'(bus.exc_flush), 32'h0);
        checkOutput("rst_busy",  32'(bus.redirect_busy), 32'h0);
        tick();
        applyStimulus(1, 0, 32'h0, 1, 0, 32'h0, 32'h0000_3000);
        checkOutput("rst_exc_npc",   bus.npc,            32'h0000_3000);
        checkOutput("rst_exc_we",    32'(bus.pc_we),     32'h0);
        checkOutput("rst_exc_flush", 32'(bus.exc_flush), 32'h0);
        tick();

        // Release: sequential fetch, stall during reset not counted.
        reset = 1'b1;
        applyStimulus(0, 0, 32'h0, 0, 0, 32'h0, 32'h0000_3000);
        checkOutput("seq_npc",   bus.npc,             32'h0000_3004);
        checkOutput("seq_we",    32'(bus.pc_we),      32'h1);
        checkOutput("seq_flush", 32'(bus.exc_flush),  32'h0);
        checkOutput("seq_cnt",   32'(bus.stall_cnt),  32'h0);
        tick();

        // Unstalled branch takes effect in the same cycle.
        applyStimulus(0, 1, 32'h0000_3400, 0, 0, 32'h0, 32'h0000_3010);
        checkOutput("br_npc",  bus.npc,                 32'h0000_3400);
        checkOutput("br_we",   32'(bus.pc_we),          32'h1);
        checkOutput("br_busy", 32'(bus.redirect_busy),  32'h0);
        tick();

        // Branch during a 3-cycle stall is buffered and applied on release.
        applyStimulus(1, 1, 32'h0000_3500, 0, 0, 32'h0, 32'h0000_3404);
        checkOutput("st1_we",   32'(bus.pc_we),         32'h0);
        checkOutput("st1_npc",  bus.npc,                32'h0000_3404);
        checkOutput("st1_busy", 32'(bus.redirect_busy), 32'h0);
        tick();
        applyStimulus(1, 0, 32'h0, 0, 0, 32'h0, 32'h0000_3404);
        checkOutput("st2_we",   32'(bus.pc_we),         32'h0);
        checkOutput("st2_busy", 32'(bus.redirect_busy), 32'h1);
        tick();
        applyStimulus(1, 0, 32'h0, 0, 0, 32'h0, 32'h0000_3404);
        checkOutput("st3_we",   32'(bus.pc_we),         32'h0);
        checkOutput("st3_busy", 32'(bus.redirect_busy), 32'h1);
        tick();
        applyStimulus(0, 0, 32'h0, 0, 0, 32'h0, 32'h0000_3404);
        checkOutput("rel_npc", bus.npc,        32'h0000_3500);
        checkOutput("rel_we",  32'(bus.pc_we), 32'h1);
        tick();
        applyStimulus(0, 0, 32'h0, 0, 0, 32'h0, 32'h0000_3500);
        checkOutput("rel_busy", 32'(bus.redirect_busy), 32'h0);
        checkOutput("rel_npc2", bus.npc,                32'h0000_3504);
        checkOutput("rel_cnt",  32'(bus.stall_cnt),     32'h3);
        tick();

        // Exception in HOLD overrides stall and discards the pending target.
        applyStimulus(1, 1, 32'h0000_3500, 0, 0, 32'h0, 32'h0000_3504);
        tick();
        applyStimulus(1, 0, 32'h0, 1, 0, 32'h0, 32'h0000_3504);
        checkOutput("exc_npc",   bus.npc,                32'h0000_4180);
        checkOutput("exc_we",    32'(bus.pc_we),         32'h1);
        checkOutput("exc_flush", 32'(bus.exc_flush),     32'h1);
        checkOutput("exc_busy",  32'(bus.redirect_busy), 32'h1);
        tick();
        applyStimulus(0, 0, 32'h0, 0, 0, 32'h0, 32'h0000_4180);
        checkOutput("pexc_busy",  32'(bus.redirect_busy), 32'h0);
        checkOutput("pexc_npc",   bus.npc,                32'h0000_4184);
        checkOutput("pexc_flush", 32'(bus.exc_flush),     32'h0);
        checkOutput("pexc_cnt",   32'(bus.stall_cnt),     32'h4);
        tick();

        // Exception beats ERET; then ERET alone.
        applyStimulus(0, 0, 32'h0, 1, 1, 32'h0000_3020, 32'h0000_4184);
        checkOutput("both_npc",   bus.npc,            32'h0000_4180);
        checkOutput("both_flush", 32'(bus.exc_flush), 32'h1);
        tick();
        applyStimulus(0, 0, 32'h0, 0, 1, 32'h0000_3020, 32'h0000_4180);
        checkOutput("eret_npc",   bus.npc,            32'h0000_3020);
        checkOutput("eret_we",    32'(bus.pc_we),     32'h1);
        checkOutput("eret_flush", 32'(bus.exc_flush), 32'h1);
        tick();
        applyStimulus(0, 0, 32'h0, 0, 0, 32'h0, 32'h0000_3020);
        checkOutput("peret_npc",   bus.npc,            32'h0000_3024);
        checkOutput("peret_flush", 32'(bus.exc_flush), 32'h0);
        tick();

        // Newest buffered branch wins.
        applyStimulus(1, 1, 32'h0000_3600, 0, 0, 32'h0, 32'h0000_3024);
        tick();
        applyStimulus(1, 1, 32'h0000_3700, 0, 0, 32'h0, 32'h0000_3024);
        checkOutput("nw_we",   32'(bus.pc_we),         32'h0);
        checkOutput("nw_busy", 32'(bus.redirect_busy), 32'h1);
        tick();
        applyStimulus(0, 0, 32'h0, 0, 0, 32'h0, 32'h0000_3024);
        checkOutput("nw_npc", bus.npc, 32'h0000_3700);
        tick();
        applyStimulus(0, 0, 32'h0, 0, 0, 32'h0, 32'h0000_3700);
        checkOutput("nw_npc2", bus.npc,                32'h0000_3704);
        checkOutput("nw_busy2", 32'(bus.redirect_busy), 32'h0);
        tick();

        // Fresh branch on release supersedes the pending one.
        applyStimulus(1, 1, 32'h0000_3900, 0, 0, 32'h0, 32'h0000_3704);
        tick();
        applyStimulus(0, 1, 32'h0000_3A00, 0, 0, 32'h0, 32'h0000_3704);
        checkOutput("fb_npc", bus.npc,        32'h0000_3A00);
        checkOutput("fb_we",  32'(bus.pc_we), 32'h1);
        tick();
        applyStimulus(0, 0, 32'h0, 0, 0, 32'h0, 32'h0000_3A00);
        checkOutput("fb_npc2",  bus.npc,                32'h0000_3A04);
        checkOutput("fb_busy2", 32'(bus.redirect_busy), 32'h0);
        tick();

        // ERET in HOLD overrides stall and discards pending.
        applyStimulus(1, 1, 32'h0000_3800, 0, 0, 32'h0, 32'h0000_3A04);
        tick();
        applyStimulus(1, 0, 32'h0, 0, 1, 32'h0000_3030, 32'h0000_3A04);
        checkOutput("her_npc",   bus.npc,            32'h0000_3030);
        checkOutput("her_we",    32'(bus.pc_we),     32'h1);
        checkOutput("her_flush", 32'(bus.exc_flush), 32'h1);
        tick();
        applyStimulus(0, 0, 32'h0, 0, 0, 32'h0, 32'h0000_3030);
        checkOutput("her_busy2", 32'(bus.redirect_busy), 32'h0);
        checkOutput("her_npc2",  bus.npc,                32'h0000_3034);
        tick();

        // Sequential add wraps modulo 2^32.
        applyStimulus(0, 0, 32'h0, 0, 0, 32'h0, 32'hFFFF_FFFC);
        checkOutput("wrap_npc", bus.npc,        32'h0000_0000);
        checkOutput("wrap_we",  32'(bus.pc_we), 32'h1);
        tick();

        // 2-bit counter saturates at 3 over a 6-cycle stall.
        bus2.stall = 1'b1;
        tick();
        tick();
        checkOutput("sat_cnt2", 32'(bus2.stall_cnt), 32'h2);
        for (int i = 0; i < 4; i++) tick();
        checkOutput("sat_cnt6", 32'(bus2.stall_cnt), 32'h3);
        bus2.stall = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures",
                 num_checks, num_fails);
        $finish;
    end

endmodule

// File: doc/f_pc_ctrl.md
Name: f_pc_ctrl

Overview:
Next-PC sequencer and write-enable scheduler for the fetch-stage PC register. It arbitrates four redirect sources: exception, ERET, D-stage branch/jump, and sequential PC+4. It drives the PC register's npc and WE. It buffers a branch redirect that arrives while fetch is stalled and applies it once the stall releases. It sits between the hazard unit, the D-stage branch logic, CP0 and the PC register.

Parameters:
RESET_PC, 32'h0000_3000, value driven on npc while reset is asserted
EXC_VECTOR, 32'h0000_4180, exception handler entry address
CNT_W, 16, width of the stall-cycle counter

Ports:
clk  input  1  system clock; all state updates on posedge
reset  input  1  synchronous, active-low reset (asserted when 0, sampled at posedge clk)
pc_cur  input  32  current PC register value
stall  input  1  hazard unit fetch stall; level
br_req  input  1  one-cycle pulse: taken branch/jump resolved in D
br_target  input  32  branch/jump target, valid with br_req
exc_req  input  1  exception/interrupt taken (from CP0), level for one cycle
eret_req  input  1  ERET committing, one cycle
epc  input  32  return address, valid with eret_req
npc  output  32  next PC to the PC register
pc_we  output  1  PC register write enable
exc_flush  output  1  flush F/D/E pipeline registers this cycle
redirect_busy  output  1  a buffered branch redirect is pending
stall_cnt  output  CNT_W  cycles with pc_we=0 due to stall, saturating

Behaviour:
- npc, pc_we, exc_flush and redirect_busy are combinational from state and inputs. The pending register, state and stall_cnt are registered.
- States: RUN, HOLD.
- Reset asserted (reset=0 at posedge):
  - Next state: RUN; pending target cleared to 0; stall_cnt cleared to 0.
  - While reset=0, outputs are forced: npc=RESET_PC, pc_we=0, exc_flush=0, redirect_busy=0.
- Selection priority, same in both states: exc_req > eret_req > stall > br_req > sequential.
- exc_req=1:
  - npc=EXC_VECTOR, pc_we=1, exc_flush=1.
  - This overrides stall. Any pending target is discarded and the next state is RUN.
- eret_req=1 (and exc_req=0):
  - npc=epc, pc_we=1, exc_flush=1.
  - This overrides stall. Pending target is discarded and the next state is RUN.
- RUN, stall=1:
  - pc_we=0, npc=pc_cur.
  - If br_req=1, latch br_target into the pending register; next state is HOLD.
- RUN, stall=0, br_req=1: npc=br_target, pc_we=1.
- RUN, otherwise: npc=pc_cur+4, pc_we=1. The add is modulo 2^32, so 32'hFFFF_FFFC wraps to 0.
- HOLD (redirect_busy=1):
  - stall=1: pc_we=0, stay in HOLD. If br_req=1, overwrite the pending target (newest wins).
  - stall=0, br_req=0: npc=pending, pc_we=1; next state is RUN.
  - stall=0, br_req=1: npc=br_target, pc_we=1. Pending is discarded; next state is RUN.
- exc_flush=1 only on exc_req or eret_req cycles; it is 0 otherwise.
- stall_cnt:
  - Increments by 1 on each posedge where reset=1, stall=1, exc_req=0 and eret_req=0.
  - Holds at all-ones once saturated.
- No latency beyond the combinational path: a request presented in cycle N is written to PC at the end of cycle N, unless stalled.

Test Plan:
1. Reset held low 2 cycles, then released with pc_cur=0x3000 and no requests → in reset npc=0x3000, pc_we=0, stall_cnt=0; after release npc=0x3004, pc_we=1.
2. pc_cur=0x3010, br_req=1, br_target=0x3400, stall=0 → same cycle npc=0x3400, pc_we=1, redirect_busy=0.
3. stall=1 for 3 cycles with br_req pulse (target 0x3500) in the first cycle, then stall=0:
   - Stalled cycles: pc_we=0, redirect_busy=1 from cycle 2.
   - Release cycle: npc=0x3500, pc_we=1, then redirect_busy=0.
   - stall_cnt=3.
4. In HOLD with pending 0x3500, exc_req=1 while stall=1 → npc=0x4180, pc_we=1, exc_flush=1. Next cycle is RUN, redirect_busy=0, and pending is not applied later.
5. eret_req=1 and exc_req=1 together, epc=0x3020 → npc=0x4180 (exception wins). Then eret_req alone → npc=0x3020, exc_flush=1.
6. pc_cur=0xFFFF_FFFC, no requests → npc=0x0000_0000. Also: with CNT_W set to 2, hold stall for 6 cycles → stall_cnt saturates at 3.
